dmem_uart_dump: RTL

Post-run memory dump engine for the rv32i single-core on the Zybo Z7-20. After a program halts, it reads a contiguous range of 32-bit words from the data BRAM debug read port and serializes them over a UART TX line (8N1), most significant byte first. It is the read-out counterpart of the bench-side data BRAM loader, so verification and board bring-up can inspect memory without simulator hierarchy access.

---
 rtl/dmem_uart_dump_if.sv | 25 ++
 rtl/dmem_uart_dump.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_uart_dump_if.sv
// Bundles the dump engine's control handshake, the data BRAM debug read port
// and the UART line. The master side is the host/memory environment (it issues
// start and returns BRAM read data); the slave side is the dump engine.
interface dmem_uart_dump_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] baseAddr;
    logic [ADDR_WIDTH-1:0] wordCount;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] debugAddr;
    logic [31:0]           debugData;
    logic                  tx;

    modport master (
        output start, baseAddr, wordCount, debugData,
        input  busy, done, debugAddr, tx
    );

    modport slave (
        input  start, baseAddr, wordCount, debugData,
        output busy, done, debugAddr, tx
    );
endinterface

// File: rtl/dmem_uart_dump.sv
// Post-run memory dump engine: reads a contiguous range of 32-bit words from
// the data BRAM debug port and sends them over an 8N1 UART line, most
// significant byte first. All outputs come straight from flops so tx is
// glitch-free and the reset forces the line idle-high immediately.
module dmem_uart_dump #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dmem_uart_dump_if.slave  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        FETCH,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remain_q;
    logic [31:0]           word_q;
    logic [7:0]            byte_q;
    logic [1:0]            idx_q;
    logic [2:0]            bitCnt_q;
    logic [CNT_W-1:0]      baud_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic baudDone;

    assign baudDone      = (baud_q == BAUD_LAST);
    assign bus.debugAddr = addr_q;
    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Dump sequencer: fetch a word, shift its four bytes out as UART frames, advance to the next word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            idx_q    <= '0;
            bitCnt_q <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.wordCount != '0) begin
                            addr_q   <= bus.baseAddr & ~ADDR_WIDTH'(3);
                            remain_q <= bus.wordCount;
                            busy_q   <= 1'b1;
                            state_q  <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                ADDR: begin
                    state_q <= FETCH;
                end

                FETCH: begin
                    word_q  <= bus.debugData;
                    idx_q   <= 2'd3;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    state_q <= START_BIT;
                end

                START_BIT: begin
                    // Reloaded every cycle of the start bit; CLKS_PER_BIT >= 2
                    // guarantees it is settled before the first data bit.
                    byte_q <= word_q[{idx_q, 3'b000} +: 8];
                    if (baudDone) begin
                        baud_q   <= '0;
                        bitCnt_q <= '0;
                        tx_q     <= byte_q[0];
                        state_q  <= DATA_BITS;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                DATA_BITS: begin
                    if (baudDone) begin
                        baud_q <= '0;
                        if (bitCnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            byte_q   <= byte_q >> 1;
                            tx_q     <= byte_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                STOP_BIT: begin
                    if (baudDone) begin
                        baud_q <= '0;
                        if (idx_q != 2'd0) begin
                            idx_q   <= idx_q - 2'd1;
                            tx_q    <= 1'b0;
                            state_q <= START_BIT;
                        end else if (remain_q > ADDR_WIDTH'(1)) begin
                            addr_q   <= addr_q + ADDR_WIDTH'(4);
                            remain_q <= remain_q - ADDR_WIDTH'(1);
                            state_q  <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
